// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Measures the high time of an incoming servo pulse train and converts it
//   back into the 8-bit angle code using the generator's pulse-width law:
//     angle = clamp(floor((W - OFFSET + CPA/2) / CPA), 0, 255)
//   The division is replaced by a prescaler that starts at W = OFFSET - CPA/2
//   and bumps a saturating accumulator every CPA cycles of high time.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pwm_in       servo pulse input, asynchronous to clk
//   angle        last decoded angle code
//   angle_valid  one-cycle strobe, angle updated
//   pulse_error  one-cycle strobe, pulse rejected (too short or too long)
//   signal_lost  level, no rising edge for TIMEOUT cycles
module servo_pwm_decoder #(
  parameter int unsigned freq       = 50_000_000,
  parameter int unsigned TIMEOUT_MS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       pulse_error,
  output logic       signal_lost
);

  localparam int unsigned C1MS     = freq / 1000;
  localparam int unsigned CPA      = (C1MS * 2) / 255;
  localparam int unsigned OFFSET   = C1MS * 22 - (C1MS * 21 + C1MS / 3);
  localparam int unsigned START    = OFFSET - CPA / 2;
  localparam int unsigned MIN_HIGH = C1MS / 2;
  localparam int unsigned MAX_HIGH = C1MS * 3;
  localparam int unsigned TIMEOUT  = C1MS * TIMEOUT_MS;

  typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;

  state_t      state, state_n;
  logic        sync1, s_pwm, s_prev;
  logic [1:0]  armed;
  logic [31:0] w, w_n, w_inc;
  logic [31:0] pc, pc_n;
  logic [7:0]  acc, acc_n;
  logic [31:0] to_cnt, to_n;
  logic [7:0]  angle_n;
  logic        valid_n, err_n, lost_n;
  logic        rise, fall;

  assign rise  = s_pwm & ~s_prev;
  assign fall  = ~s_pwm & s_prev;
  assign w_inc = w + 32'd1;

  // Synchronizer, edge-detect register and a two-cycle warm-up flag. SYNC
  // must not trust s_pwm until the synchronizer holds a real sample of the
  // pin, otherwise a pulse in progress at reset release would look like a
  // fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      s_pwm  <= 1'b0;
      s_prev <= 1'b0;
      armed  <= 2'b00;
    end else begin
      sync1  <= pwm_in;
      s_pwm  <= sync1;
      s_prev <= s_pwm;
      armed  <= {armed[0], 1'b1};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      w           <= '0;
      pc          <= '0;
      acc         <= '0;
      to_cnt      <= '0;
      angle       <= '0;
      angle_valid <= 1'b0;
      pulse_error <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      state       <= state_n;
      w           <= w_n;
      pc          <= pc_n;
      acc         <= acc_n;
      to_cnt      <= to_n;
      angle       <= angle_n;
      angle_valid <= valid_n;
      pulse_error <= err_n;
      signal_lost <= lost_n;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_n = state;
    w_n     = w;
    pc_n    = pc;
    acc_n   = acc;
    angle_n = angle;
    valid_n = 1'b0;
    err_n   = 1'b0;

    unique case (state)
      SYNC: begin
        if (armed[1] && !s_pwm) state_n = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          w_n     = 32'd1;
          pc_n    = '0;
          acc_n   = '0;
        end
      end
      HIGH: begin
        if (fall) begin
          state_n = IDLE;
          if (w < MIN_HIGH) begin
            err_n = 1'b1;
          end else begin
            // acc stays 0 until W reaches START, which covers the
            // negative-numerator case of the law.
            angle_n = acc;
            valid_n = 1'b1;
          end
        end else if (s_pwm) begin
          if (w >= MAX_HIGH) begin
            // Over-length: abandon the pulse; SYNC swallows its falling edge.
            err_n   = 1'b1;
            state_n = SYNC;
          end else begin
            w_n = w_inc;
            // Invariant once started: acc = floor((W - START) / CPA),
            // pc = (W - START) mod CPA.
            if (w_inc == START) begin
              pc_n  = '0;
              acc_n = '0;
            end else if (w_inc > START) begin
              if (pc == CPA - 1) begin
                pc_n = '0;
                if (acc != 8'hFF) acc_n = acc + 8'd1;
              end else begin
                pc_n = pc + 32'd1;
              end
            end
          end
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // Loss-of-signal timer: cleared by every rise, saturating otherwise. The
  // flag is set on the cycle the count reaches TIMEOUT; a simultaneous valid
  // decode takes priority and clears it.
  always_comb begin
    to_n   = to_cnt;
    lost_n = signal_lost;
    if (rise) begin
      to_n = '0;
    end else if (to_cnt != TIMEOUT) begin
      to_n = to_cnt + 32'd1;
    end
    if (valid_n) begin
      lost_n = 1'b0;
    end else if (!rise && to_cnt == TIMEOUT - 1) begin
      lost_n = 1'b1;
    end
  end

endmodule
